// File: rtl/keypad_pio_in_if.sv
// rtl/keypad_pio_in_if.sv - register bus and interrupt bundle for keypad_pio_in
interface keypad_pio_in_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;
  logic             irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/keypad_pio_in.sv
// rtl/keypad_pio_in.sv - keypad input port: sync, level, sticky edge capture, maskable irq
// Optional per-line debounce is compiled in with KEYPAD_DEBOUNCE_EN.
module keypad_pio_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_port,
  keypad_pio_in_if.slave     bus
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wr_clr;
  logic [1:0]       prime;
  logic             primed;
  logic             wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      prev <= level;
    end
  end

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] deb;

  // A line only changes its debounced value after s2 has disagreed with it
  // for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = deb;
`else
  assign level = s2;
`endif

  always_comb begin
    edges = '0;
    case (EDGE_TYPE)
      0:       edges = level & ~prev;
      1:       edges = ~level & prev;
      default: edges = level ^ prev;
    endcase
  end

  // Hold off capture until the pipeline has refilled after reset, so lines
  // already high at release do not look like fresh edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      prime <= 2'd0;
    end else if (prime != 2'd3) begin
      prime <= prime + 2'd1;
    end
  end

  assign primed = (prime == 2'd3);
  assign wr_en  = bus.chipselect & ~bus.write_n;
  assign wr_clr = (wr_en && bus.address == 2'd3) ? bus.writedata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && bus.address == 2'd2) irq_mask <= bus.writedata;
      // Set after clear so a same-cycle edge survives the clearing write.
      edge_capture <= (edge_capture & ~wr_clr) | (edges & {WIDTH{primed}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
    end else begin
      case (bus.address)
        2'd0:    bus.readdata <= level;
        2'd1:    bus.readdata <= '0;
        2'd2:    bus.readdata <= irq_mask;
        default: bus.readdata <= edge_capture;
      endcase
    end
  end

  assign bus.irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_keypad_pio_in.sv
// tb/tb_keypad_pio_in.sv - scoreboard bench for keypad_pio_in (rising and any-edge instances)
module tb_keypad_pio_in;

  typedef struct {
    string      name;
    logic [3:0] exp;
    int         dut;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in0 = 4'h0;
  logic [3:0] in1 = 4'h0;
  logic       rd_fire = 1'b0;
  logic       rd_done = 1'b0;
  logic       irq_fire = 1'b0;
  int         errors = 0;
  int         checks = 0;
  item_t      rd_q[$];
  item_t      irq_q[$];

  always #5 clk = ~clk;

  keypad_pio_in_if #(.WIDTH(4)) b0 ();
  keypad_pio_in_if #(.WIDTH(4)) b1 ();

  keypad_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)) dut0 (
    .clk(clk), .reset(reset), .in_port(in0), .bus(b0)
  );
  keypad_pio_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)) dut1 (
    .clk(clk), .reset(reset), .in_port(in1), .bus(b1)
  );

  always @(posedge clk) rd_done <= rd_fire;

  always @(negedge clk) begin
    item_t it;
    logic [3:0] act;
    if (rd_done) begin
      if (rd_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL rd_underflow: read completed with no expectation queued");
      end else begin
        it = rd_q.pop_front();
        act = (it.dut == 0) ? b0.readdata : b1.readdata;
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: readdata=%h expected=%h", it.name, act, it.exp);
        end
      end
    end
    if (irq_fire && irq_q.size() != 0) begin
      it = irq_q.pop_front();
      act = {3'b000, (it.dut == 0) ? b0.irq : b1.irq};
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: irq=%h expected=%h", it.name, act, it.exp);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    b0.chipselect = 1'b0; b0.write_n = 1'b1; b0.address = 2'd0; b0.writedata = 4'h0;
    b1.chipselect = 1'b0; b1.write_n = 1'b1; b1.address = 2'd0; b1.writedata = 4'h0;
  endtask

  task automatic set_bus(input int d, input logic [1:0] a, input logic [3:0] v, input logic wn);
    if (d == 0) begin
      b0.address = a; b0.writedata = v; b0.chipselect = 1'b1; b0.write_n = wn;
    end else begin
      b1.address = a; b1.writedata = v; b1.chipselect = 1'b1; b1.write_n = wn;
    end
  endtask

  task automatic bus_write(input int d, input logic [1:0] a, input logic [3:0] v);
    set_bus(d, a, v, 1'b0);
    step(1);
    idle();
  endtask

  task automatic bus_read(input int d, input logic [1:0] a, input logic [3:0] exp, input string name);
    item_t it;
    it.name = name; it.exp = exp; it.dut = d;
    rd_q.push_back(it);
    set_bus(d, a, 4'h0, 1'b1);
    rd_fire = 1'b1;
    step(1);
    rd_fire = 1'b0;
    idle();
  endtask

  task automatic check_irq(input int d, input logic exp, input string name);
    item_t it;
    it.name = name; it.exp = {3'b000, exp}; it.dut = d;
    irq_q.push_back(it);
    irq_fire = 1'b1;
    step(1);
    irq_fire = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    in0 = 4'hF;
    step(2);
    bus_read(0, 2'd0, 4'h0, "reset_readdata");
    check_irq(0, 1'b0, "reset_irq");
    reset = 1'b0;

`ifdef KEYPAD_DEBOUNCE_EN
    in0 = 4'h0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);
    bus_write(0, 2'd2, 4'b0001);
    in0 = 4'b0001;
    step(5);
    in0 = 4'b0000;
    step(15);
    bus_read(0, 2'd0, 4'h0, "deb_glitch_data");
    bus_read(0, 2'd3, 4'h0, "deb_glitch_capture");
    check_irq(0, 1'b0, "deb_glitch_irq");
    in0 = 4'b0001;
    step(16);
    bus_read(0, 2'd0, 4'h1, "deb_hold_data");
    bus_read(0, 2'd3, 4'h1, "deb_hold_capture");
    check_irq(0, 1'b1, "deb_hold_irq");
`else
    // Static input held high through reset
    for (int i = 0; i < 100; i++) check_irq(0, 1'b0, "static_irq");
    bus_read(0, 2'd0, 4'hF, "static_data");
    bus_read(0, 2'd3, 4'h0, "static_capture");

    // Rising capture on bit1
    bus_write(0, 2'd2, 4'b0010);
    in0 = 4'h0;
    step(5);
    in0 = 4'b0010;
    step(2);
    check_irq(0, 1'b0, "rise_irq_early");
    check_irq(0, 1'b1, "rise_irq");
    bus_read(0, 2'd3, 4'h2, "rise_capture");

    // Clear, then clear of an unrelated bit
    bus_write(0, 2'd3, 4'b0010);
    check_irq(0, 1'b0, "clear_irq");
    bus_read(0, 2'd3, 4'h0, "clear_capture");
    in0 = 4'h0;
    step(4);
    in0 = 4'b0010;
    step(4);
    bus_write(0, 2'd3, 4'b0001);
    bus_read(0, 2'd3, 4'h2, "clear_other_bit");
    check_irq(0, 1'b1, "clear_other_irq");

    // Set/clear collision on bit0
    bus_write(0, 2'd2, 4'b0001);
    bus_write(0, 2'd3, 4'b0010);
    check_irq(0, 1'b0, "coll_pre_irq");
    in0 = 4'b0011;
    step(2);
    bus_write(0, 2'd3, 4'b0001);
    bus_read(0, 2'd3, 4'h1, "coll_capture");
    check_irq(0, 1'b1, "coll_irq");

    // Reset mid-operation with lines held high
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);
    bus_read(0, 2'd2, 4'h0, "rst_mask");
    bus_read(0, 2'd3, 4'h0, "rst_capture");
    bus_read(0, 2'd0, 4'h3, "rst_data");
    check_irq(0, 1'b0, "rst_irq");

    // Any-edge instance with mask gating
    bus_write(1, 2'd2, 4'h0);
    in1 = 4'b1000;
    step(5);
    in1 = 4'b0000;
    step(5);
    bus_read(1, 2'd3, 4'h8, "any_capture");
    check_irq(1, 1'b0, "any_masked_irq");
    bus_write(1, 2'd2, 4'b1000);
    check_irq(1, 1'b1, "any_unmasked_irq");
    bus_read(1, 2'd1, 4'h0, "reserved_reads_zero");
    bus_read(1, 2'd2, 4'h8, "mask_readback");
    bus_write(1, 2'd0, 4'hF);
    bus_read(1, 2'd0, 4'h0, "data_write_ignored");
`endif

    step(3);
    checks++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: rd_left=%0d irq_left=%0d expected=0", rd_q.size(), irq_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
